// File: rtl/rr_stream_mux.sv
// N-channel registered stream multiplexer with valid/ready handshakes.
// Arbitration is either by external select (MODE 0) or round-robin from a fairness pointer.
module rr_stream_mux #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 1,
  parameter int unsigned MODE = 1,
  localparam int unsigned SW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_nxt;
  logic [SW-1:0] gidx;
  logic [N-1:0]  grant;
  logic          any_grant;
  logic          load_en;
  logic [W-1:0]  gdata;

  assign load_en = !out_valid || out_ready;

  always_comb begin : arbitrate
    int unsigned c;
    logic [SW-1:0] ci;
    grant     = '0;
    any_grant = 1'b0;
    gidx      = '0;
    c         = 0;
    ci        = '0;
    if (MODE == 0) begin
      if (32'(sel) >= N) gidx = SW'(N - 1);
      else               gidx = sel;
      any_grant   = in_valid[gidx];
      grant[gidx] = in_valid[gidx];
    end else begin
      // First requester at or after ptr, wrapping modulo N.
      for (int unsigned k = 0; k < N; k++) begin
        c  = (32'(ptr) + k) % N;
        ci = SW'(c);
        if (!any_grant && in_valid[ci]) begin
          any_grant = 1'b1;
          gidx      = ci;
          grant[ci] = 1'b1;
        end
      end
    end
  end

  always_comb begin : data_mux
    gdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) gdata = in_data[i*W +: W];
    end
  end

  assign ptr_nxt = (32'(gidx) == N - 1) ? '0 : gidx + SW'(1);

  // Reset blocks acceptance so nothing is handshaken into a register being cleared.
  assign in_ready = (load_en && !rst) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= any_grant;
      if (any_grant) begin
        out_data <= gdata;
        out_ch   <= gidx;
        if (MODE != 0) ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed and randomized checks of rr_stream_mux in select and round-robin modes.
module tb_rr_stream_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // u0: MODE0 N=4 W=8
  logic [31:0] d0;
  logic [3:0]  v0, r0;
  logic [1:0]  s0, oc0;
  logic [7:0]  od0;
  logic        ov0, ordy0;
  // u1: MODE0 N=3 W=8
  logic [23:0] d1;
  logic [2:0]  v1, r1;
  logic [1:0]  s1, oc1;
  logic [7:0]  od1;
  logic        ov1, ordy1;
  // u2: MODE1 N=4 W=8
  logic [31:0] d2;
  logic [3:0]  v2, r2;
  logic [1:0]  s2, oc2;
  logic [7:0]  od2;
  logic        ov2, ordy2;

  rr_stream_mux #(.N(4), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(s0),
    .out_data(od0), .out_ch(oc0), .out_valid(ov0), .out_ready(ordy0));
  rr_stream_mux #(.N(3), .W(8), .MODE(0)) u1 (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(s1),
    .out_data(od1), .out_ch(oc1), .out_valid(ov1), .out_ready(ordy1));
  rr_stream_mux #(.N(4), .W(8), .MODE(1)) u2 (
    .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2), .sel(s2),
    .out_data(od2), .out_ch(oc2), .out_valid(ov2), .out_ready(ordy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference grant: channel index or -1 when nothing is granted.
  function automatic int exp_grant(int mode, int s, logic [3:0] v, int p, int n);
    if (mode == 0) begin
      int e = (s >= n) ? n - 1 : s;
      return v[e] ? e : -1;
    end
    for (int k = 0; k < n; k++) begin
      int c = (p + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Model state for the random phase: [0] follows u0, [1] follows u2.
  logic       mv [2];
  logic [7:0] md [2];
  int         mc [2];
  int         mp [2];

  initial begin
    rst = 1'b1;
    v0 = 4'hf; v1 = 3'h7; v2 = 4'hf;
    d0 = 32'hdeadbeef; d1 = 24'h123456; d2 = 32'hcafef00d;
    s0 = 2'd2; s1 = 2'd1; s2 = 2'd0;
    ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;

    // T1: reset with every channel requesting
    tick(); tick();
    chk("t1_ov0", 32'(ov0), 0); chk("t1_od0", 32'(od0), 0); chk("t1_oc0", 32'(oc0), 0); chk("t1_r0", 32'(r0), 0);
    chk("t1_ov1", 32'(ov1), 0); chk("t1_od1", 32'(od1), 0); chk("t1_oc1", 32'(oc1), 0); chk("t1_r1", 32'(r1), 0);
    chk("t1_ov2", 32'(ov2), 0); chk("t1_od2", 32'(od2), 0); chk("t1_oc2", 32'(oc2), 0); chk("t1_r2", 32'(r2), 0);

    // T2 on u0 and T3 on u1 in parallel
    rst = 1'b0;
    d0 = {8'h44, 8'hA5, 8'h22, 8'h11}; s0 = 2'd2; v0 = 4'hf;
    d1 = {8'h3C, 8'h22, 8'h11};        s1 = 2'd3; v1 = 3'h7;
    #1;
    chk("t2_r0", 32'(r0), 32'b0100);
    chk("t3_r1", 32'(r1), 32'b100);
    tick();
    chk("t2_ov0", 32'(ov0), 1); chk("t2_od0", 32'(od0), 32'hA5); chk("t2_oc0", 32'(oc0), 2);
    chk("t3_ov1", 32'(ov1), 1); chk("t3_od1", 32'(od1), 32'h3C); chk("t3_oc1", 32'(oc1), 2);
    // selected channel idle: no grant, valid drops, data/ch hold
    s0 = 2'd0; v0 = 4'b1110;
    v1 = 3'b011;
    #1;
    chk("t2_idle_r0", 32'(r0), 0);
    chk("t3_idle_r1", 32'(r1), 0);
    tick();
    chk("t2_idle_ov0", 32'(ov0), 0); chk("t2_idle_od0", 32'(od0), 32'hA5); chk("t2_idle_oc0", 32'(oc0), 2);
    chk("t3_idle_ov1", 32'(ov1), 0); chk("t3_idle_oc1", 32'(oc1), 2);

    // T4: round-robin, all requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v2 = 4'hf; d2 = {8'h13, 8'h12, 8'h11, 8'h10}; ordy2 = 1'b1;
    #1;
    chk("t4_r2_first", 32'(r2), 32'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t4_ov2", 32'(ov2), 1);
      chk("t4_oc2", 32'(oc2), 32'(k % 4));
      chk("t4_od2", 32'(od2), 32'(8'h10 + k % 4));
      chk("t4_r2", 32'(r2), 32'(1) << ((k + 1) % 4));
    end

    // T5: backpressure with ch3 held, ptr at 0
    ordy2 = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t5_r2_full", 32'(r2), 0);
      tick();
      chk("t5_ov2", 32'(ov2), 1);
      chk("t5_oc2", 32'(oc2), 3);
      chk("t5_od2", 32'(od2), 32'h13);
    end
    ordy2 = 1'b1;
    #1;
    chk("t5_r2_release", 32'(r2), 32'b0001);
    tick();
    chk("t5_oc2_next", 32'(oc2), 0);
    chk("t5_od2_next", 32'(od2), 32'h10);
    chk("t5_ov2_next", 32'(ov2), 1);

    // T6: sparse requesters with wrap, then reset mid-stream
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v2 = 4'b0001;
    #1;
    chk("t6_r2_ch0", 32'(r2), 32'b0001);
    tick();
    chk("t6_oc2_ch0", 32'(oc2), 0);
    v2 = 4'b1001;
    #1;
    chk("t6_r2_a", 32'(r2), 32'b1000);
    tick();
    chk("t6_oc2_a", 32'(oc2), 3);
    chk("t6_r2_b", 32'(r2), 32'b0001);
    tick();
    chk("t6_oc2_b", 32'(oc2), 0);
    chk("t6_r2_c", 32'(r2), 32'b1000);
    tick();
    chk("t6_oc2_c", 32'(oc2), 3);
    chk("t6_ov2_c", 32'(ov2), 1);
    rst = 1'b1;
    tick();
    chk("t6_ov2_rst", 32'(ov2), 0);
    rst = 1'b0;
    v2 = 4'hf;
    #1;
    chk("t6_r2_ptr0", 32'(r2), 32'b0001);

    // Random phase against the reference model
    rst = 1'b1; v1 = 3'h0;
    tick();
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; md[m] = '0; mc[m] = 0; mp[m] = 0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      int g0, g2;
      logic le0, le2;
      logic [31:0] tmp;
      v0 = 4'($urandom); d0 = $urandom; s0 = 2'($urandom); ordy0 = ($urandom_range(0, 3) != 0);
      v2 = 4'($urandom); d2 = $urandom; s2 = 2'($urandom); ordy2 = ($urandom_range(0, 3) != 0);
      #1;
      le0 = !mv[0] || ordy0;
      le2 = !mv[1] || ordy2;
      g0 = exp_grant(0, int'(s0), v0, 0, 4);
      g2 = exp_grant(1, 0, v2, mp[1], 4);
      chk("rnd_r0", 32'(r0), (le0 && g0 >= 0) ? (32'(1) << g0) : 32'(0));
      chk("rnd_r2", 32'(r2), (le2 && g2 >= 0) ? (32'(1) << g2) : 32'(0));
      if (le0) begin
        if (g0 >= 0) begin
          tmp = d0;
          mv[0] = 1'b1; md[0] = tmp[g0*8 +: 8]; mc[0] = g0;
        end else mv[0] = 1'b0;
      end
      if (le2) begin
        if (g2 >= 0) begin
          tmp = d2;
          mv[1] = 1'b1; md[1] = tmp[g2*8 +: 8]; mc[1] = g2;
          mp[1] = (g2 + 1) % 4;
        end else mv[1] = 1'b0;
      end
      tick();
      chk("rnd_ov0", 32'(ov0), 32'(mv[0])); chk("rnd_od0", 32'(od0), 32'(md[0])); chk("rnd_oc0", 32'(oc0), 32'(mc[0]));
      chk("rnd_ov2", 32'(ov2), 32'(mv[1])); chk("rnd_od2", 32'(od2), 32'(md[1])); chk("rnd_oc2", 32'(oc2), 32'(mc[1]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
